exec_cluster: RTL and testbench

Two-slot in-order execute cluster for the dual-issue core: decodes an instruction pair, pairs or splits it, executes both slots on two ALUs and serves loads/stores from a private data memory. It sits between the instruction fetch / PC unit and the register file. It provides register read addresses, registered write-back, branch redirect and a pair-acceptance signal back to fetch.

---
 rtl/exec_cluster_if.sv | 31 +++
 rtl/exec_cluster.sv | 203 ++++++++++++++++++++
 tb/tb_exec_cluster.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/exec_cluster_if.sv
// Bus bundle between the execute cluster and its neighbours: the instruction
// pair from fetch, register-file read ports, write-back and branch redirect.
interface exec_cluster_if;
  logic [31:0] inst0;
  logic [31:0] inst1;
  logic [31:0] pc_in;
  logic        take2;
  logic [4:0]  ra0, rb0, rc0, ra1, rb1, rc1;
  logic [31:0] a0, b0, c0, a1, b1, c1;
  logic        wb_en0, wb_en1;
  logic [4:0]  wb_addr0, wb_addr1;
  logic [31:0] wb_data0, wb_data1;
  logic        br_taken;
  logic [31:0] br_target;

  // Fetch / register-file side.
  modport master (
    output inst0, inst1, pc_in, a0, b0, c0, a1, b1, c1,
    input  take2, ra0, rb0, rc0, ra1, rb1, rc1,
    input  wb_en0, wb_en1, wb_addr0, wb_addr1, wb_data0, wb_data1,
    input  br_taken, br_target
  );

  // Execute cluster side.
  modport slave (
    input  inst0, inst1, pc_in, a0, b0, c0, a1, b1, c1,
    output take2, ra0, rb0, rc0, ra1, rb1, rc1,
    output wb_en0, wb_en1, wb_addr0, wb_addr1, wb_data0, wb_data1,
    output br_taken, br_target
  );
endinterface

// File: rtl/exec_cluster.sv
// Two-slot in-order execute cluster: pairing decision, D register, two ALUs
// with write-back forwarding, a private 1024x32 data memory and slot-0 branches.
module exec_cluster (
  input logic          clk,
  input logic          reset,
  exec_cluster_if.slave bus
);
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLT  = 6'd6;
  localparam logic [5:0] OP_SLL  = 6'd7;
  localparam logic [5:0] OP_SRL  = 6'd8;
  localparam logic [5:0] OP_ADDI = 6'd9;
  localparam logic [5:0] OP_LW   = 6'd10;
  localparam logic [5:0] OP_SW   = 6'd11;
  localparam logic [5:0] OP_BEQ  = 6'd12;
  localparam logic [5:0] OP_JMP  = 6'd13;

  function automatic logic writes_rd(input logic [5:0] op);
    return (op >= OP_ADD) && (op <= OP_LW);
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_JMP);
  endfunction

  // Newest write-back wins: slot 1 is younger than slot 0. r0 is never bypassed.
  function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] rf_data,
                                      input logic en0, input logic [4:0] addr0, input logic [31:0] data0,
                                      input logic en1, input logic [4:0] addr1, input logic [31:0] data1);
    if (addr == 5'd0)                return rf_data;
    else if (en1 && (addr1 == addr)) return data1;
    else if (en0 && (addr0 == addr)) return data0;
    else                              return rf_data;
  endfunction

  logic        take2;
  logic [31:0] d_inst_reg [2];
  logic [31:0] d_pc_reg;
  logic        wb_en0_reg, wb_en1_reg;
  logic [4:0]  wb_addr0_reg, wb_addr1_reg;
  logic [31:0] wb_data0_reg, wb_data1_reg;
  logic        br_taken_reg;
  logic [31:0] br_target_reg;
  logic [31:0] ld_data;
  logic        squash;

  // Pairing decision on the raw fetch pair; independent of pipeline state.
  always_comb begin
    take2 = 1'b1;
    if (is_branch(bus.inst0[31:26]) || is_branch(bus.inst1[31:26]))
      take2 = 1'b0;
    if (is_mem(bus.inst0[31:26]) && is_mem(bus.inst1[31:26]))
      take2 = 1'b0;
    if (writes_rd(bus.inst0[31:26]) && (bus.inst0[25:21] != 5'd0) &&
        ((bus.inst0[25:21] == bus.inst1[25:21]) ||
         (bus.inst0[25:21] == bus.inst1[20:16]) ||
         (bus.inst0[25:21] == bus.inst1[15:11])))
      take2 = 1'b0;
  end

  // D register: loads the accepted pair, or a NOP pair after a redirect.
  always_ff @(posedge clk) begin
    if (reset || squash) begin
      d_inst_reg[0] <= 32'd0;
      d_inst_reg[1] <= 32'd0;
      d_pc_reg      <= 32'd0;
    end else begin
      d_inst_reg[0] <= bus.inst0;
      d_inst_reg[1] <= take2 ? bus.inst1 : 32'd0;
      d_pc_reg      <= bus.pc_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [5:0]  op;
      logic [4:0]  rd, rs, rt;
      logic [31:0] sext, opa, opb, opc, eff, res;
      logic        wen, mem_op;

      assign op     = d_inst_reg[gi][31:26];
      assign rd     = d_inst_reg[gi][25:21];
      assign rs     = d_inst_reg[gi][20:16];
      assign rt     = d_inst_reg[gi][15:11];
      assign sext   = {{16{d_inst_reg[gi][15]}}, d_inst_reg[gi][15:0]};
      assign opa    = fwd(rd, (gi == 0) ? bus.a0 : bus.a1, wb_en0_reg, wb_addr0_reg, wb_data0_reg,
                          wb_en1_reg, wb_addr1_reg, wb_data1_reg);
      assign opb    = fwd(rs, (gi == 0) ? bus.b0 : bus.b1, wb_en0_reg, wb_addr0_reg, wb_data0_reg,
                          wb_en1_reg, wb_addr1_reg, wb_data1_reg);
      assign opc    = fwd(rt, (gi == 0) ? bus.c0 : bus.c1, wb_en0_reg, wb_addr0_reg, wb_data0_reg,
                          wb_en1_reg, wb_addr1_reg, wb_data1_reg);
      assign eff    = opb + sext;
      assign wen    = writes_rd(op) && (rd != 5'd0);
      assign mem_op = is_mem(op);

      // Slot ALU; loads take the memory word selected for this cycle.
      always_comb begin
        res = 32'd0;
        case (op)
          OP_ADD:  res = opb + opc;
          OP_SUB:  res = opb - opc;
          OP_AND:  res = opb & opc;
          OP_OR:   res = opb | opc;
          OP_XOR:  res = opb ^ opc;
          OP_SLT:  res = {31'd0, $signed(opb) < $signed(opc)};
          OP_SLL:  res = opb << opc[4:0];
          OP_SRL:  res = opb >> opc[4:0];
          OP_ADDI: res = eff;
          OP_LW:   res = ld_data;
          default: res = 32'd0;
        endcase
      end
    end
  endgenerate

  assign bus.ra0 = g_slot[0].rd;
  assign bus.rb0 = g_slot[0].rs;
  assign bus.rc0 = g_slot[0].rt;
  assign bus.ra1 = g_slot[1].rd;
  assign bus.rb1 = g_slot[1].rs;
  assign bus.rc1 = g_slot[1].rt;

  // At most one slot holds a memory op, so a single port serves the pair.
  logic [31:0] mem [1024];
  logic [31:0] mem_eff;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] st_data;
  logic [3:0]  unused_addr_bits;

  assign mem_eff          = g_slot[1].mem_op ? g_slot[1].eff : g_slot[0].eff;
  assign mem_addr         = mem_eff[11:2];
  assign unused_addr_bits = {^mem_eff[31:12], mem_eff[1:0], 1'b0};
  assign mem_we           = g_slot[1].mem_op ? (g_slot[1].op == OP_SW) : (g_slot[0].op == OP_SW);
  assign st_data          = g_slot[1].mem_op ? g_slot[1].opa : g_slot[0].opa;
  assign ld_data          = mem[mem_addr];

  // Store port; contents are not reset, and a store in E is dropped on reset.
  always_ff @(posedge clk) begin
    if (!reset && mem_we)
      mem[mem_addr] <= st_data;
  end

  // Slot-0 branch resolution.
  logic        br_now;
  logic [31:0] br_tgt;
  always_comb begin
    br_now = 1'b0;
    br_tgt = d_pc_reg + 32'd4 + {g_slot[0].sext[29:0], 2'b00};
    if (g_slot[0].op == OP_BEQ) begin
      br_now = (g_slot[0].opa == g_slot[0].opb);
    end else if (g_slot[0].op == OP_JMP) begin
      br_now = 1'b1;
      br_tgt = {d_pc_reg[31:28], d_inst_reg[0][25:0], 2'b00};
    end
  end

  // Kill the pair entering D now and the one behind it.
  assign squash = br_now || br_taken_reg;

  // Write-back and redirect registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en0_reg    <= 1'b0;
      wb_en1_reg    <= 1'b0;
      wb_addr0_reg  <= 5'd0;
      wb_addr1_reg  <= 5'd0;
      wb_data0_reg  <= 32'd0;
      wb_data1_reg  <= 32'd0;
      br_taken_reg  <= 1'b0;
      br_target_reg <= 32'd0;
    end else begin
      wb_en0_reg    <= g_slot[0].wen;
      wb_en1_reg    <= g_slot[1].wen;
      wb_addr0_reg  <= g_slot[0].rd;
      wb_addr1_reg  <= g_slot[1].rd;
      wb_data0_reg  <= g_slot[0].res;
      wb_data1_reg  <= g_slot[1].res;
      br_taken_reg  <= br_now;
      if (br_now)
        br_target_reg <= br_tgt;
    end
  end

  assign bus.take2     = take2;
  assign bus.wb_en0    = wb_en0_reg;
  assign bus.wb_en1    = wb_en1_reg;
  assign bus.wb_addr0  = wb_addr0_reg;
  assign bus.wb_addr1  = wb_addr1_reg;
  assign bus.wb_data0  = wb_data0_reg;
  assign bus.wb_data1  = wb_data1_reg;
  assign bus.br_taken  = br_taken_reg;
  assign bus.br_target = br_target_reg;
endmodule

// File: tb/tb_exec_cluster.sv
// Directed bench for exec_cluster: a table of independent pairs plus
// hand-written forwarding, memory, branch and reset sequences.
module tb_exec_cluster;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exec_cluster_if bus();
  exec_cluster dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Register file model: async read, write at the end of the write-back cycle.
  logic [31:0] rf [32];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_addr = 5'd0;
  logic [31:0] pre_data = 32'd0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      if (pre_we) rf[pre_addr] <= pre_data;
      if (bus.wb_en0) rf[bus.wb_addr0] <= bus.wb_data0;
      if (bus.wb_en1) rf[bus.wb_addr1] <= bus.wb_data1;
    end
  end

  always_comb begin
    bus.a0 = rf[bus.ra0];
    bus.b0 = rf[bus.rb0];
    bus.c0 = rf[bus.rc0];
    bus.a1 = rf[bus.ra1];
    bus.b1 = rf[bus.rb1];
    bus.c1 = rf[bus.rc1];
  end

  function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt);
    return {op[5:0], rd[4:0], rs[4:0], rt[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] enci(input int op, input int rd, input int rs, input logic [15:0] imm);
    return {op[5:0], rd[4:0], rs[4:0], imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
    bus.inst0 = i0;
    bus.inst1 = i1;
    bus.pc_in = pc;
    #1;
    $display("pair pc=%h inst0=%h inst1=%h take2=%0b", pc, i0, i1, bus.take2);
  endtask

  task automatic chk_wb(input string tag, input logic e0, input logic [4:0] ad0, input logic [31:0] d0,
                        input logic e1, input logic [4:0] ad1, input logic [31:0] d1);
    chk({tag, " wb_en0"}, {31'd0, bus.wb_en0}, {31'd0, e0});
    if (e0) begin
      chk({tag, " wb_addr0"}, {27'd0, bus.wb_addr0}, {27'd0, ad0});
      chk({tag, " wb_data0"}, bus.wb_data0, d0);
    end
    chk({tag, " wb_en1"}, {31'd0, bus.wb_en1}, {31'd0, e1});
    if (e1) begin
      chk({tag, " wb_addr1"}, {27'd0, bus.wb_addr1}, {27'd0, ad1});
      chk({tag, " wb_data1"}, bus.wb_data1, d1);
    end
  endtask

  typedef struct {
    logic [31:0] i0, i1;
    logic        t2;
    logic        e0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        e1;
    logic [4:0]  a1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{enci(9,1,0,16'd5),      enci(9,2,0,16'hFFFD), 1'b1, 1'b1, 5'd1,  32'd5,        1'b1, 5'd2,  32'hFFFFFFFD};
    vecs[1] = '{enc(1,3,1,2),           enc(2,4,1,2),         1'b1, 1'b1, 5'd3,  32'd2,        1'b1, 5'd4,  32'd8};
    vecs[2] = '{enc(3,5,1,2),           enc(4,6,1,2),         1'b1, 1'b1, 5'd5,  32'd5,        1'b1, 5'd6,  32'hFFFFFFFD};
    vecs[3] = '{enc(5,7,1,2),           enc(6,8,2,1),         1'b1, 1'b1, 5'd7,  32'hFFFFFFF8, 1'b1, 5'd8,  32'd1};
    vecs[4] = '{enc(7,9,1,1),           enc(8,10,2,1),        1'b1, 1'b1, 5'd9,  32'h000000A0, 1'b1, 5'd10, 32'h07FFFFFF};
    vecs[5] = '{enci(9,0,0,16'd9),      enc(63,11,1,2),       1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0};
    vecs[6] = '{enci(11,0,0,16'h40),    enci(10,12,0,16'h40), 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0};
    vecs[7] = '{enci(10,12,0,16'h40),   enci(9,13,0,16'd1),   1'b1, 1'b1, 5'd12, 32'd0,        1'b1, 5'd13, 32'd1};

    // Reset state; take2 must already be valid while reset is held.
    reset = 1'b1;
    drive(enci(13,0,0,16'h0040), 32'd0, 32'd0);
    step();
    step();
    chk("take2 jmp in reset", {31'd0, bus.take2}, 32'd0);
    chk_wb("reset", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("reset wb_addr0", {27'd0, bus.wb_addr0}, 32'd0);
    chk("reset wb_data1", bus.wb_data1, 32'd0);
    chk("reset br_taken", {31'd0, bus.br_taken}, 32'd0);
    chk("reset br_target", bus.br_target, 32'd0);
    reset = 1'b0;
    drive(32'd0, 32'd0, 32'd0);
    step();

    // Table: each pair alone, results two cycles later.
    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].i0, vecs[v].i1, 32'd0);
      chk($sformatf("vec%0d take2", v), {31'd0, bus.take2}, {31'd0, vecs[v].t2});
      step();
      drive(32'd0, 32'd0, 32'd0);
      step();
      chk_wb($sformatf("vec%0d", v), vecs[v].e0, vecs[v].a0, vecs[v].d0, vecs[v].e1, vecs[v].a1, vecs[v].d1);
    end

    // Intra-pair dependency, then the deferred ADD with r1 forwarded (r1 was 5).
    drive(enci(9,1,0,16'd7), enc(1,2,1,1), 32'd0);
    chk("dep take2 split", {31'd0, bus.take2}, 32'd0);
    step();
    drive(enc(1,2,1,1), 32'd0, 32'd4);
    chk("dep take2 next", {31'd0, bus.take2}, 32'd1);
    step();
    drive(32'd0, 32'd0, 32'd0);
    chk_wb("dep addi", 1'b1, 5'd1, 32'd7, 1'b0, 5'd0, 32'd0);
    step();
    chk_wb("dep fwd add", 1'b1, 5'd2, 32'd14, 1'b0, 5'd0, 32'd0);

    // Store then load one pair later.
    pre_we = 1'b1; pre_addr = 5'd1; pre_data = 32'hDEADBEEF;
    step();
    pre_we = 1'b0;
    drive(enci(11,1,0,16'h10), 32'd0, 32'd0);
    step();
    drive(enci(10,3,0,16'h10), 32'd0, 32'd0);
    step();
    drive(32'd0, 32'd0, 32'd0);
    chk_wb("sw", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    chk_wb("lw", 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);

    // Branch: clear 0x30/0x34, then BEQ with stores in the shadow.
    drive(enci(11,0,0,16'h30), 32'd0, 32'd0);
    step();
    drive(enci(11,0,0,16'h34), 32'd0, 32'd0);
    step();
    drive(enci(12,0,0,16'd4), enci(9,20,0,16'd1), 32'h100);
    chk("beq take2", {31'd0, bus.take2}, 32'd0);
    step();
    drive(enci(9,21,0,16'd1), enci(11,1,0,16'h30), 32'h104);
    step();
    chk("br_taken pulse", {31'd0, bus.br_taken}, 32'd1);
    chk("br_target", bus.br_target, 32'h114);
    chk_wb("beq pair", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(enci(9,22,0,16'd1), enci(11,1,0,16'h34), 32'h10C);
    step();
    chk("br_taken end", {31'd0, bus.br_taken}, 32'd0);
    chk_wb("squash1", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(32'd0, 32'd0, 32'd0);
    step();
    chk_wb("squash2", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(enci(10,23,0,16'h30), 32'd0, 32'd0);
    step();
    drive(enci(10,24,0,16'h34), 32'd0, 32'd0);
    step();
    drive(32'd0, 32'd0, 32'd0);
    chk_wb("no store 0x30", 1'b1, 5'd23, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    chk_wb("no store 0x34", 1'b1, 5'd24, 32'd0, 1'b0, 5'd0, 32'd0);

    // Reset with a store in E: memory keeps its old (zero) value.
    drive(enci(11,0,0,16'h50), 32'd0, 32'd0);
    step();
    drive(enci(11,1,0,16'h50), enci(9,25,0,16'd9), 32'd0);
    step();
    reset = 1'b1;
    drive(32'd0, 32'd0, 32'd0);
    step();
    chk_wb("mid reset", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("mid reset wb_addr1", {27'd0, bus.wb_addr1}, 32'd0);
    chk("mid reset wb_data1", bus.wb_data1, 32'd0);
    chk("mid reset br_taken", {31'd0, bus.br_taken}, 32'd0);
    chk("mid reset br_target", bus.br_target, 32'd0);
    reset = 1'b0;
    drive(enci(10,26,0,16'h50), 32'd0, 32'd0);
    step();
    drive(32'd0, 32'd0, 32'd0);
    step();
    chk_wb("store dropped", 1'b1, 5'd26, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
